adsr_envelope: RTL and testbench

//  Parametrised ADSR envelope generator with note-length counter for one ACP wave channel.
//  - Sits between a channel's raw waveform source and the mixer.
//  - A trigger pulse starts a note. Volume steps through Attack -> Decay -> Sustain -> Release at programmable rates.
//  - The scaled waveform and a channel enable are driven out.

---
 rtl/acp_env_pkg.sv | 16 +
 rtl/env_rate_timer.sv | 32 +++
 rtl/adsr_envelope.sv | 187 ++++++++++++++++++
 tb/tb_adsr_envelope.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/acp_env_pkg.sv
// Shared types and default widths for the ACP wave-channel envelope generator.
package acp_env_pkg;

  localparam int DEF_VOL_W  = 4;
  localparam int DEF_RATE_W = 4;
  localparam int DEF_LEN_W  = 16;

  typedef enum logic [2:0] {
    IDLE,
    ATTACK,
    DECAY,
    SUSTAIN,
    RELEASE
  } env_state_t;

endpackage

// File: rtl/env_rate_timer.sv
// Rate down-counter shared by all envelope phases: load sets the period, step fires at count 1
// (or immediately when loaded with 0, which the caller treats as a jump).
module env_rate_timer
  import acp_env_pkg::*;
#(
  parameter int RATE_W = DEF_RATE_W
) (
  input  logic              note_clk,
  input  logic              rst,
  input  logic              load,
  input  logic [RATE_W-1:0] load_val,
  input  logic              tick,
  output logic              step
);

  localparam logic [RATE_W-1:0] RATE_ONE = {{(RATE_W-1){1'b0}}, 1'b1};

  logic [RATE_W-1:0] cnt_reg;

  assign step = tick && (cnt_reg <= RATE_ONE);

  always_ff @(posedge note_clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (tick && (cnt_reg > RATE_ONE)) begin
      cnt_reg <= cnt_reg - RATE_ONE;
    end
  end

endmodule

// File: rtl/adsr_envelope.sv
// ADSR envelope with note-length counter and output scaler for one ACP wave channel.
// Optional gated sustain (gate_in port) is built when ENV_GATE_SUSTAIN_EN is defined.
module adsr_envelope
  import acp_env_pkg::*;
#(
  parameter int VOL_W  = DEF_VOL_W,
  parameter int RATE_W = DEF_RATE_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              note_clk,
  input  logic              rst,
  input  logic              trigger,
  input  logic [RATE_W-1:0] attack_rate,
  input  logic [RATE_W-1:0] decay_rate,
  input  logic [VOL_W-1:0]  sustain_lvl,
  input  logic [RATE_W-1:0] release_rate,
  input  logic [LEN_W-1:0]  note_len,
`ifdef ENV_GATE_SUSTAIN_EN
  input  logic              gate_in,
`endif
  input  logic [VOL_W-1:0]  wave_in,
  output logic [VOL_W-1:0]  wave_out,
  output logic [VOL_W-1:0]  env_vol,
  output logic              enable_out
);

  localparam logic [VOL_W-1:0] VMAX    = {VOL_W{1'b1}};
  localparam logic [VOL_W-1:0] VOL_ONE = {{(VOL_W-1){1'b0}}, 1'b1};

  env_state_t        state_reg, state_next, post_attack;
  logic [VOL_W-1:0]  env_vol_reg, vol_next, vol_dec;
  logic [LEN_W-1:0]  len_cnt_reg, len_next;
  logic [LEN_W:0]    len_inc;
  logic [RATE_W-1:0] atk_lat_reg, dec_lat_reg, rel_lat_reg;
  logic [VOL_W-1:0]  sus_lat_reg;
  logic [LEN_W-1:0]  len_lat_reg;
  logic [VOL_W-1:0]  wave_out_reg;
  logic              enable_reg;
  logic              active, expire, gate_fall;
  logic              tmr_load, tmr_tick, tmr_step;
  logic [RATE_W-1:0] tmr_load_val;
  logic [2*VOL_W-1:0] wave_ext, gain_ext, prod;

  env_rate_timer #(
    .RATE_W(RATE_W)
  ) u_rate_timer (
    .note_clk(note_clk),
    .rst     (rst),
    .load    (tmr_load),
    .load_val(tmr_load_val),
    .tick    (tmr_tick),
    .step    (tmr_step)
  );

`ifdef ENV_GATE_SUSTAIN_EN
  logic gate_d_reg;

  always_ff @(posedge note_clk or posedge rst) begin
    if (rst) begin
      gate_d_reg <= 1'b0;
    end else begin
      gate_d_reg <= gate_in;
    end
  end

  assign gate_fall = gate_d_reg && !gate_in;
`else
  assign gate_fall = 1'b0;
`endif

  assign active      = (state_reg == ATTACK) || (state_reg == DECAY) || (state_reg == SUSTAIN);
  assign tmr_tick    = (state_reg == ATTACK) || (state_reg == DECAY) || (state_reg == RELEASE);
  assign len_inc     = {1'b0, len_cnt_reg} + 1'b1;
  assign expire      = active && (len_inc >= {1'b0, len_lat_reg});
  assign vol_dec     = env_vol_reg - VOL_ONE;
  assign post_attack = (sus_lat_reg == VMAX) ? SUSTAIN : DECAY;

  // Length expiry and gate release leave the volume where it is; the release ramp starts from there.
  always_comb begin
    state_next = state_reg;
    vol_next   = env_vol_reg;
    len_next   = len_cnt_reg;
    if (trigger) begin
      state_next = ATTACK;
      len_next   = '0;
    end else begin
      if (active) begin
        len_next = len_inc[LEN_W-1:0];
      end
      if (expire || (active && gate_fall)) begin
        state_next = RELEASE;
      end else begin
        case (state_reg)
          ATTACK: begin
            if (env_vol_reg == VMAX) begin
              state_next = post_attack;
            end else if (tmr_step) begin
              if ((atk_lat_reg == '0) || (env_vol_reg == VMAX - VOL_ONE)) begin
                vol_next   = VMAX;
                state_next = post_attack;
              end else begin
                vol_next = env_vol_reg + VOL_ONE;
              end
            end
          end
          DECAY: begin
            if (env_vol_reg <= sus_lat_reg) begin
              state_next = SUSTAIN;
            end else if (tmr_step) begin
              if ((dec_lat_reg == '0) || (vol_dec <= sus_lat_reg)) begin
                vol_next   = sus_lat_reg;
                state_next = SUSTAIN;
              end else begin
                vol_next = vol_dec;
              end
            end
          end
          RELEASE: begin
            if (env_vol_reg == '0) begin
              state_next = IDLE;
            end else if (tmr_step) begin
              if ((rel_lat_reg == '0) || (env_vol_reg == VOL_ONE)) begin
                vol_next   = '0;
                state_next = IDLE;
              end else begin
                vol_next = vol_dec;
              end
            end
          end
          default: state_next = state_reg;
        endcase
      end
    end
  end

  // The trigger cycle loads the raw input rate because the latched copy is not valid yet.
  always_comb begin
    tmr_load = trigger || tmr_step || (state_next != state_reg);
    if (trigger) begin
      tmr_load_val = attack_rate;
    end else begin
      case (state_next)
        ATTACK:  tmr_load_val = atk_lat_reg;
        DECAY:   tmr_load_val = dec_lat_reg;
        RELEASE: tmr_load_val = rel_lat_reg;
        default: tmr_load_val = '0;
      endcase
    end
  end

  assign wave_ext = {{VOL_W{1'b0}}, wave_in};
  assign gain_ext = {{VOL_W{1'b0}}, env_vol_reg} + 1'b1;
  assign prod     = wave_ext * gain_ext;

  always_ff @(posedge note_clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      env_vol_reg  <= '0;
      len_cnt_reg  <= '0;
      atk_lat_reg  <= '0;
      dec_lat_reg  <= '0;
      sus_lat_reg  <= '0;
      rel_lat_reg  <= '0;
      len_lat_reg  <= '0;
      wave_out_reg <= '0;
      enable_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      env_vol_reg  <= vol_next;
      len_cnt_reg  <= len_next;
      enable_reg   <= (state_next != IDLE);
      wave_out_reg <= (state_reg == IDLE) ? '0 : prod[2*VOL_W-1:VOL_W];
      if (trigger) begin
        atk_lat_reg <= attack_rate;
        dec_lat_reg <= decay_rate;
        sus_lat_reg <= sustain_lvl;
        rel_lat_reg <= release_rate;
        len_lat_reg <= note_len;
      end
    end
  end

  assign env_vol    = env_vol_reg;
  assign wave_out   = wave_out_reg;
  assign enable_out = enable_reg;

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed bench for adsr_envelope: expectations are queued per note cycle and checked at negedge.
module tb_adsr_envelope;

  logic        note_clk;
  logic        rst;
  logic        trigger;
  logic [3:0]  attack_rate, decay_rate, sustain_lvl, release_rate;
  logic [15:0] note_len;
  logic [3:0]  wave_in, wave_out, env_vol;
  logic        enable_out;
`ifdef ENV_GATE_SUSTAIN_EN
  logic        gate_in;
`endif

  adsr_envelope #(.VOL_W(4), .RATE_W(4), .LEN_W(16)) dut (
    .note_clk    (note_clk),
    .rst         (rst),
    .trigger     (trigger),
    .attack_rate (attack_rate),
    .decay_rate  (decay_rate),
    .sustain_lvl (sustain_lvl),
    .release_rate(release_rate),
    .note_len    (note_len),
`ifdef ENV_GATE_SUSTAIN_EN
    .gate_in     (gate_in),
`endif
    .wave_in     (wave_in),
    .wave_out    (wave_out),
    .env_vol     (env_vol),
    .enable_out  (enable_out)
  );

  initial note_clk = 1'b0;
  always #5 note_clk = ~note_clk;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] val;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   n_assert;
  int   n_fail;

  localparam int S_VOL = 0;
  localparam int S_WAVE = 1;
  localparam int S_EN = 2;

  function automatic logic [31:0] observe(int s);
    case (s)
      S_VOL:   return {28'd0, env_vol};
      S_WAVE:  return {28'd0, wave_out};
      default: return {31'd0, enable_out};
    endcase
  endfunction

  task automatic push(int c, int s, int v, string t);
    exp_t e;
    e.cyc = c;
    e.sig = s;
    e.val = v;
    e.tag = t;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] o;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      o = observe(e.sig);
      n_assert++;
      assert (o === e.val) else begin
        n_fail++;
        $error("FAIL %s cyc=%0d observed=%0d expected=%0d", e.tag, e.cyc, o, e.val);
      end
    end
  endtask

  task automatic run_to(int c);
    drain();
    while (cyc < c) begin
      @(negedge note_clk);
      cyc++;
      drain();
    end
  endtask

  // Pulses trigger for one edge, then scrambles the config inputs so only latched values can matter.
  task automatic do_trigger(int atk, int dec, int sus, int rel, int len);
    attack_rate  = 4'(atk);
    decay_rate   = 4'(dec);
    sustain_lvl  = 4'(sus);
    release_rate = 4'(rel);
    note_len     = 16'(len);
    trigger      = 1'b1;
    @(negedge note_clk);
    trigger      = 1'b0;
    attack_rate  = 4'hF;
    decay_rate   = 4'hE;
    sustain_lvl  = 4'h3;
    release_rate = 4'hD;
    note_len     = 16'd7;
    cyc          = 0;
    $display("trigger atk=%0d dec=%0d sus=%0d rel=%0d len=%0d", atk, dec, sus, rel, len);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge note_clk);
    rst = 1'b0;
    @(negedge note_clk);
  endtask

  initial begin
    n_assert     = 0;
    n_fail       = 0;
    cyc          = 0;
    rst          = 1'b1;
    trigger      = 1'b0;
    attack_rate  = '0;
    decay_rate   = '0;
    sustain_lvl  = '0;
    release_rate = '0;
    note_len     = '0;
    wave_in      = 4'd15;
`ifdef ENV_GATE_SUSTAIN_EN
    gate_in      = 1'b1;
`endif
    repeat (2) @(negedge note_clk);
    push(0, S_VOL, 0, "reset_vol");
    push(0, S_WAVE, 0, "reset_wave");
    push(0, S_EN, 0, "reset_en");
    drain();
    rst = 1'b0;
    @(negedge note_clk);

    // Full trajectory: attack 2, decay 1 to 8, sustain to 100, release 3.
    do_trigger(2, 1, 8, 3, 100);
    push(0, S_EN, 1, "traj_en_rise");
    push(0, S_VOL, 0, "traj_vol0");
    push(1, S_WAVE, 0, "traj_wave_vol0");
    push(29, S_VOL, 14, "traj_vol29");
    push(30, S_VOL, 15, "traj_peak");
    push(31, S_WAVE, 15, "traj_wave_peak");
    push(36, S_VOL, 9, "traj_vol36");
    push(37, S_VOL, 8, "traj_sustain");
    push(38, S_WAVE, 8, "traj_wave_sus");
    push(99, S_VOL, 8, "traj_vol99");
    push(100, S_VOL, 8, "traj_rel_entry");
    push(103, S_VOL, 7, "traj_rel_step");
    push(123, S_VOL, 1, "traj_vol123");
    push(123, S_EN, 1, "traj_en123");
    push(124, S_VOL, 0, "traj_vol124");
    push(124, S_EN, 0, "traj_en_fall");
    push(125, S_WAVE, 0, "traj_wave_idle");
    run_to(125);

    // Asynchronous reset in the middle of a note.
    do_trigger(1, 1, 8, 1, 100);
    push(5, S_VOL, 5, "rst_pre_vol");
    push(5, S_WAVE, 4, "rst_pre_wave");
    run_to(5);
    #2 rst = 1'b1;
    #1;
    push(cyc, S_VOL, 0, "rst_async_vol");
    push(cyc, S_WAVE, 0, "rst_async_wave");
    push(cyc, S_EN, 0, "rst_async_en");
    drain();
    @(negedge note_clk);
    rst = 1'b0;
    cyc = 0;
    push(3, S_EN, 0, "rst_idle_en");
    push(3, S_VOL, 0, "rst_idle_vol");
    run_to(3);

    // Output scaling: zero attack jumps to full volume, full volume passes the sample through.
    do_trigger(0, 0, 15, 0, 1000);
    push(0, S_VOL, 0, "scale_vol0");
    push(1, S_VOL, 15, "scale_jump");
    push(2, S_WAVE, 15, "scale_full15");
    run_to(2);
    wave_in = 4'd10;
    push(3, S_WAVE, 10, "scale_full10");
    run_to(3);
    wave_in = 4'd15;
    do_reset();

    do_trigger(1, 0, 15, 0, 1000);
    push(1, S_WAVE, 0, "scale_vol_zero");
    push(3, S_VOL, 3, "scale_vol3");
    push(7, S_VOL, 7, "scale_vol7");
    push(8, S_WAVE, 7, "scale_half");
    run_to(8);
    do_reset();

    // Length expiry mid-attack goes straight to release from the current volume.
    do_trigger(3, 1, 8, 2, 10);
    push(9, S_VOL, 3, "early_vol9");
    push(10, S_VOL, 3, "early_rel_entry");
    push(11, S_VOL, 3, "early_vol11");
    push(12, S_VOL, 2, "early_rel_step");
    push(15, S_EN, 1, "early_en15");
    push(16, S_VOL, 0, "early_vol16");
    push(16, S_EN, 0, "early_idle");
    run_to(16);

    // Zero length: release on the first cycle, then idle because volume is already 0.
    do_trigger(3, 1, 8, 2, 0);
    push(0, S_EN, 1, "zlen_en0");
    push(1, S_EN, 1, "zlen_en1");
    push(2, S_EN, 0, "zlen_idle");
    push(3, S_VOL, 0, "zlen_no_attack");
    run_to(3);

    // Retrigger during release resumes attack from the current volume.
    do_trigger(1, 1, 8, 4, 10);
    push(9, S_VOL, 9, "retrig_vol9");
    push(10, S_VOL, 9, "retrig_rel_entry");
    push(14, S_VOL, 8, "retrig_rel_step");
    push(26, S_VOL, 5, "retrig_vol5");
    run_to(26);
    do_trigger(2, 1, 8, 4, 100);
    push(0, S_VOL, 5, "retrig_hold5");
    push(1, S_VOL, 5, "retrig_wait");
    push(2, S_VOL, 6, "retrig_up6");
    push(2, S_EN, 1, "retrig_en");
    run_to(2);
    do_reset();

    // Trigger landing on the length-expiry edge wins over release.
    do_trigger(1, 1, 8, 1, 5);
    push(4, S_VOL, 4, "conflict_vol4");
    run_to(4);
    do_trigger(1, 1, 8, 1, 100);
    push(0, S_VOL, 4, "conflict_hold");
    push(1, S_VOL, 5, "conflict_up5");
    push(2, S_VOL, 6, "conflict_up6");
    push(2, S_EN, 1, "conflict_en");
    run_to(2);
    do_reset();

`ifdef ENV_GATE_SUSTAIN_EN
    // Gate falling during sustain ends the note before the length counter does.
    gate_in = 1'b1;
    do_trigger(1, 1, 8, 1, 1000);
    push(50, S_VOL, 8, "gate_sus");
    run_to(50);
    gate_in = 1'b0;
    push(51, S_VOL, 8, "gate_rel_entry");
    push(52, S_VOL, 7, "gate_rel_step");
    push(52, S_EN, 1, "gate_en");
    run_to(52);
    do_reset();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
